interval_timer: RTL and testbench
=================================

# interval_timer

Reloadable down-counting interval timer for the traffic-light controller. The controller FSM loads a duration in seconds on `start_timer`. The timer decrements once per `oneHz_enable` tick from the divider and pulses `expired` for one clock when the interval has elapsed. It sits between the 1 Hz divider and the light-sequencing FSM.

## Interface
- `VALUE_W`, default 4: width of the duration input and of the internal counter.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `Reset_Sync`  input  1: asynchronous, active-high reset. The historical port name is kept; the behaviour is asynchronous.
- `Value`  input  VALUE_W: duration in 1 Hz ticks, unsigned, 0 to 2^VALUE_W−1.
- `oneHz_enable`  input  1: tick qualifier. Each clock edge sampling it high is one elapsed second.
- `start_timer`  input  1: load/restart request, sampled each rising edge.
- `expired`  output  1: registered one-clock pulse marking completion of the interval.

## Operation
- States: IDLE, RUN.
- `count` is a VALUE_W-bit register.
- `Reset_Sync` high, asynchronously:
  - state goes to IDLE, `count` to 0, `expired` to 0.
  - It stays so while reset is high and overrides all other inputs.
- Priority at each rising edge, with reset low: `start_timer`, then tick, then hold.
- `start_timer`=1 in any state:
  - `count` is loaded with `Value` and `expired` goes to 0.
  - If `Value`≠0, state goes to RUN. A start during RUN restarts the interval and discards the old count.
  - If `Value`=0, state stays or returns to IDLE and `expired` goes to 1 on this edge. The zero-length interval expires immediately, independent of `oneHz_enable`.
  - A tick on the same edge as start is ignored; it does not decrement.
- RUN with `oneHz_enable`=1 and `start_timer`=0:
  - If `count`>1: `count` becomes count−1 and `expired` is 0.
  - If `count`==1: `count` becomes 0, `expired` becomes 1, state goes to IDLE.
- RUN with `oneHz_enable`=0: hold `count`; `expired` is 0.
- IDLE with no start: `count` holds; `expired` is 0. Ticks are ignored, so there is no underflow and no wrap.
- `expired` is never high for two consecutive cycles unless a new start with `Value`=0 occurs.
- `Value` is sampled only on the start edge. Changes while in RUN have no effect.

## Timing
- Start latency: `count` is valid on the edge that samples `start_timer`.
- Expiry: `expired` rises on the same edge that samples the N-th qualifying tick after the start edge (N=`Value`). It is visible in the following cycle and lasts exactly one clock.
- `Value`=0: `expired` goes high on the start edge itself, for one clock.
- With ticks every other clock and N=6, `expired` is high in the cycle after the 6th tick, 12 clocks after start.
- Reset mid-RUN:
  - The interval is aborted and no `expired` pulse occurs.
  - After release, the timer waits in IDLE for a new start.
- Start coincident with reset: reset wins and the start is lost.
- `oneHz_enable` held high continuously is legal: the count decrements every clock.

## Structure
- Shared package `tlc_pkg`:
  - `TIMER_W` (=4), used as the default of `VALUE_W`.
  - State enum `timer_state_t` with IDLE and RUN.
  - Duration constants used by the controller FSM, e.g. green/yellow/walk seconds.
- One natural sub-module: `down_counter`.
  - Inputs: load, load value, decrement enable.
  - Outputs: count and a `is_one` flag.
  - The top level adds the state register, priority logic and the `expired` register.
- No combinational path from any input to `expired`.

## Test plan
- Reset dominance: assert `Reset_Sync` together with `start_timer`=1 and `Value`=6. Require `expired`=0 and no expiry for 30 clocks with ticks every other clock.
- Nominal count: start with `Value`=6, ticks every other clock. Require a single `expired` pulse of one clock after the 6th tick, then IDLE with `expired`=0.
- Restart mid-run: `Value`=5, start, apply 3 ticks, then start again with `Value`=2. Require `expired` only after 2 further ticks; there is never a pulse at the original 5th tick.
- Zero duration: start with `Value`=0 and `oneHz_enable`=0. Require `expired`=1 for exactly one clock immediately after the start edge.
- Tick/start collision and hold: start with `Value`=3 on an edge where `oneHz_enable`=1. Require that tick not to count, so expiry comes after 3 later ticks. With the enable low for 20 clocks mid-run, the count holds.
- Async reset mid-run: `Value`=15, run 4 ticks, pulse `Reset_Sync` between clock edges. Require `expired`=0 at once, no pulse afterwards, and a clean restart on the next start.

Source files
------------

// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types and constants for the traffic-light controller.
package tlc_pkg;

    localparam int TIMER_W = 4;

    typedef enum logic {
        IDLE,
        RUN
    } timer_state_t;

    // Phase durations the light-sequencing FSM loads into the interval timer, in seconds.
    localparam logic [TIMER_W-1:0] GREEN_SECS  = 4'd10;
    localparam logic [TIMER_W-1:0] YELLOW_SECS = 4'd3;
    localparam logic [TIMER_W-1:0] RED_SECS    = 4'd12;
    localparam logic [TIMER_W-1:0] WALK_SECS   = 4'd6;

endpackage

// File: rtl/down_counter.sv
// down_counter: loadable down counter that saturates at zero and flags a count of one.
module down_counter
    import tlc_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         is_one_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = load_i ? load_val_i : (dec_i && count_q != '0) ? count_q - W'(1) : count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o  = count_q;
    assign is_one_o = count_q == W'(1);

endmodule

// File: rtl/interval_timer.sv
// interval_timer: reloadable 1 Hz down-counting timer with a registered one-clock expiry pulse.
module interval_timer
    import tlc_pkg::*;
#(
    parameter int VALUE_W = TIMER_W
) (
    input  logic               clk,
    input  logic               Reset_Sync,
    input  logic [VALUE_W-1:0] Value,
    input  logic               oneHz_enable,
    input  logic               start_timer,
    output logic               expired
);

    timer_state_t       state_q;
    logic               expired_q;
    logic [VALUE_W-1:0] count;
    logic               is_one;
    logic               tick_run;

    // A start on the same edge swallows the tick.
    assign tick_run = state_q == RUN && oneHz_enable && !start_timer && count != '0;

    down_counter #(.W(VALUE_W)) u_cnt (
        .clk       (clk),
        .rst       (Reset_Sync),
        .load_i    (start_timer),
        .load_val_i(Value),
        .dec_i     (tick_run),
        .count_o   (count),
        .is_one_o  (is_one)
    );

    always_ff @(posedge clk or posedge Reset_Sync) begin
        if (Reset_Sync) begin
            state_q   <= IDLE;
            expired_q <= 1'b0;
        end else if (start_timer) begin
            state_q   <= (Value != '0) ? RUN : IDLE;
            expired_q <= Value == '0;
        end else if (tick_run && is_one) begin
            state_q   <= IDLE;
            expired_q <= 1'b1;
        end else begin
            expired_q <= 1'b0;
        end
    end

    assign expired = expired_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: directed checks of the interval timer with hand-computed expiry times.
module tb_interval_timer;

    logic       clk = 1'b0;
    logic       Reset_Sync = 1'b0;
    logic [3:0] Value = '0;
    logic       oneHz_enable = 1'b0;
    logic       start_timer = 1'b0;
    logic       expired;

    int total = 0;
    int passed = 0;
    int pulses;
    int first;

    interval_timer dut (
        .clk         (clk),
        .Reset_Sync  (Reset_Sync),
        .Value       (Value),
        .oneHz_enable(oneHz_enable),
        .start_timer (start_timer),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input logic s, input logic t);
        start_timer  = s;
        oneHz_enable = t;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] v, input logic t);
        Value = v;
        cyc(1'b1, t);
    endtask

    // n idle-start cycles, tick every per-th cycle (0 = never); records pulse count and first pulse cycle.
    task automatic run_ticks(input int n, input int per);
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= n; i++) begin
            cyc(1'b0, per != 0 && i % per == 0);
            if (expired) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    initial begin
        Reset_Sync = 1'b1;
        Value = 4'd6;
        start_timer = 1'b1;
        #1;
        chk("reset_expired", expired, 0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        chk("reset_with_start", expired, 0);
        Reset_Sync = 1'b0;
        run_ticks(30, 2);
        chk("reset_dominance_pulses", pulses, 0);

        start(4'd6, 1'b0);
        chk("nominal_after_start", expired, 0);
        run_ticks(24, 2);
        chk("nominal_first", first, 12);
        chk("nominal_pulses", pulses, 1);

        start(4'd5, 1'b0);
        run_ticks(6, 2);
        chk("restart_pre_pulses", pulses, 0);
        start(4'd2, 1'b0);
        Value = 4'd9;
        run_ticks(12, 2);
        chk("restart_first", first, 4);
        chk("restart_pulses", pulses, 1);

        start(4'd0, 1'b0);
        chk("zero_pulse", expired, 1);
        cyc(1'b0, 1'b0);
        chk("zero_one_clock", expired, 0);
        start(4'd0, 1'b1);
        chk("zero_back_to_back_a", expired, 1);
        start(4'd0, 1'b0);
        chk("zero_back_to_back_b", expired, 1);
        cyc(1'b0, 1'b1);
        chk("zero_back_to_back_end", expired, 0);

        start(4'd3, 1'b1);
        chk("collide_after_start", expired, 0);
        run_ticks(1, 1);
        run_ticks(20, 0);
        chk("hold_pulses", pulses, 0);
        run_ticks(6, 1);
        chk("collide_first", first, 2);
        chk("collide_pulses", pulses, 1);

        start(4'd15, 1'b0);
        run_ticks(8, 2);
        chk("async_pre_pulses", pulses, 0);
        #3 Reset_Sync = 1'b1;
        #1;
        chk("async_in_reset", expired, 0);
        #1 Reset_Sync = 1'b0;
        @(posedge clk);
        #1;
        run_ticks(40, 2);
        chk("async_after_pulses", pulses, 0);

        start(4'd0, 1'b0);
        chk("async_zero_pulse", expired, 1);
        #2 Reset_Sync = 1'b1;
        #1;
        chk("async_clears_expired", expired, 0);
        #1 Reset_Sync = 1'b0;
        @(posedge clk);
        #1;

        start(4'd2, 1'b0);
        run_ticks(8, 1);
        chk("async_restart_first", first, 2);
        chk("async_restart_pulses", pulses, 1);

        start(4'd15, 1'b0);
        run_ticks(20, 1);
        chk("max_first", first, 15);
        chk("max_pulses", pulses, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
